// File: rtl/dram_arbiter.sv
// dram_arbiter: shares one DRAM controller user port between two requesters.
// A registered owner bit picks which requester may issue; the command path is
// combinational. A read-tag FIFO records the issuer of every accepted read,
// so returned data goes back to the right requester in issue order.
// Build option: define DRAM_ARBITER_RR_EN for round-robin ownership;
// leave it undefined for fixed priority (requester 0 highest).
module dram_arbiter #(
    parameter int ADDR_WIDTH = 27,
    parameter int DATA_WIDTH = 128,
    parameter int MASK_WIDTH = 16,
    parameter int TAG_DEPTH  = 32
) (
    input  logic                  clk,
    input  logic                  i_rst,
    // requester 0
    input  logic                  i_req0,
    input  logic                  i_ren0,
    input  logic                  i_wen0,
    input  logic [ADDR_WIDTH-1:0] i_addr0,
    input  logic [DATA_WIDTH-1:0] i_data0,
    input  logic [MASK_WIDTH-1:0] i_mask0,
    input  logic                  i_busy0,
    output logic                  o_busy0,
    output logic                  o_data_valid0,
    // requester 1
    input  logic                  i_req1,
    input  logic                  i_ren1,
    input  logic                  i_wen1,
    input  logic [ADDR_WIDTH-1:0] i_addr1,
    input  logic [DATA_WIDTH-1:0] i_data1,
    input  logic [MASK_WIDTH-1:0] i_mask1,
    input  logic                  i_busy1,
    output logic                  o_busy1,
    output logic                  o_data_valid1,
    // shared read data
    output logic [DATA_WIDTH-1:0] o_data,
    // command to the DRAM controller
    output logic                  o_ren,
    output logic                  o_wen,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic [MASK_WIDTH-1:0] o_mask,
    output logic                  o_dram_busy_in,
    // responses from the DRAM controller
    input  logic [DATA_WIDTH-1:0] i_dram_data,
    input  logic                  i_dram_data_valid,
    input  logic                  i_dram_busy,
    // sticky error: read data arrived with no outstanding read
    output logic                  o_err
);

    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    // state
    logic                 owner_q, owner_d;
    logic [TAG_DEPTH-1:0] tag_q, tag_d;
    logic [PTR_W-1:0]     wptr_q, wptr_d;
    logic [PTR_W-1:0]     rptr_q, rptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;

    // combinational helpers
    logic tag_empty_s;
    logic tag_full_s;
    logic head_s;
    logic busy0_s;
    logic busy1_s;
    logic own_busy_s;
    logic own_ren_s;
    logic own_wen_s;
    logic push_s;
    logic pop_s;

    // FIFO status and the requester ID at the head of the tag FIFO
    always_comb begin
        tag_empty_s = (cnt_q == {CNT_W{1'b0}});
        tag_full_s  = (cnt_q == CNT_W'(TAG_DEPTH));
        head_s      = tag_q[rptr_q];
    end

    // Busy flags depend only on registered state and DRAM busy, never on strobes;
    // reset forces both high so nothing is issued while the arbiter initialises.
    always_comb begin
        busy0_s = i_rst | i_dram_busy | tag_full_s | owner_q;
        busy1_s = i_rst | i_dram_busy | tag_full_s | ~owner_q;
        o_busy0 = busy0_s;
        o_busy1 = busy1_s;
    end

    // Combinational command mux from the current owner; a strobe seen while the
    // owner is busy is suppressed so it can never reach the controller or tag FIFO.
    always_comb begin
        if (owner_q) begin
            own_busy_s = busy1_s;
            own_ren_s  = i_ren1;
            own_wen_s  = i_wen1;
            o_addr     = i_addr1;
            o_wdata    = i_data1;
            o_mask     = i_mask1;
        end else begin
            own_busy_s = busy0_s;
            own_ren_s  = i_ren0;
            own_wen_s  = i_wen0;
            o_addr     = i_addr0;
            o_wdata    = i_data0;
            o_mask     = i_mask0;
        end
        o_ren  = own_ren_s & ~own_busy_s;
        o_wen  = own_wen_s & ~own_busy_s & ~own_ren_s;
        push_s = o_ren;
    end

    // Read-data routing: the head tag selects the requester that sees valid data
    always_comb begin
        pop_s         = i_dram_data_valid & ~tag_empty_s & ~i_rst;
        o_data_valid0 = pop_s & ~head_s;
        o_data_valid1 = pop_s & head_s;
        o_data        = i_dram_data;
        if (tag_empty_s) begin
            o_dram_busy_in = 1'b0;
        end else if (head_s) begin
            o_dram_busy_in = i_busy1;
        end else begin
            o_dram_busy_in = i_busy0;
        end
        o_err = err_q;
    end

    // Tag FIFO next state: push on accepted read, pop on returned data
    always_comb begin
        tag_d  = tag_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (push_s) begin
            tag_d[wptr_q] = owner_q;
            wptr_d        = wptr_q + PTR_W'(1);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = rptr_q + PTR_W'(1);
        end else begin
            rptr_d = rptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Error flag: data arriving with no outstanding read is dropped and flagged
    always_comb begin
        if (i_dram_data_valid && tag_empty_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

`ifdef DRAM_ARBITER_RR_EN
    // Round-robin ownership: hand over after an accepted command or when the
    // owner has nothing pending, but only if the other side wants the port.
    always_comb begin
        logic own_req_s;
        logic oth_req_s;
        own_req_s = owner_q ? i_req1 : i_req0;
        oth_req_s = owner_q ? i_req0 : i_req1;
        if (oth_req_s && ((o_ren | o_wen) || !own_req_s)) begin
            owner_d = ~owner_q;
        end else begin
            owner_d = owner_q;
        end
    end
`else
    // Fixed-priority ownership: requester 0 always wins when it has work
    always_comb begin
        if (i_req0) begin
            owner_d = 1'b0;
        end else if (i_req1) begin
            owner_d = 1'b1;
        end else begin
            owner_d = owner_q;
        end
    end
`endif

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (i_rst) begin
            owner_q <= 1'b0;
            tag_q   <= {TAG_DEPTH{1'b0}};
            wptr_q  <= {PTR_W{1'b0}};
            rptr_q  <= {PTR_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            err_q   <= 1'b0;
        end else begin
            owner_q <= owner_d;
            tag_q   <= tag_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed self-checking bench for dram_arbiter (TAG_DEPTH = 4).
// Inputs are driven 1 time unit after the rising edge and outputs are
// compared a unit later, well away from the active edge.
module tb_dram_arbiter;

    localparam int AW = 27;
    localparam int DW = 128;
    localparam int MW = 16;

    logic          clk;
    logic          i_rst;
    logic          i_req0, i_ren0, i_wen0, i_busy0;
    logic          i_req1, i_ren1, i_wen1, i_busy1;
    logic [AW-1:0] i_addr0, i_addr1;
    logic [DW-1:0] i_data0, i_data1;
    logic [MW-1:0] i_mask0, i_mask1;
    logic          o_busy0, o_busy1, o_data_valid0, o_data_valid1;
    logic [DW-1:0] o_data;
    logic          o_ren, o_wen;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_wdata;
    logic [MW-1:0] o_mask;
    logic          o_dram_busy_in;
    logic [DW-1:0] i_dram_data;
    logic          i_dram_data_valid, i_dram_busy;
    logic          o_err;

    int n_checks = 0;
    int n_errors = 0;

    dram_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MASK_WIDTH(MW), .TAG_DEPTH(4)
    ) dut (
        .clk(clk), .i_rst(i_rst),
        .i_req0(i_req0), .i_ren0(i_ren0), .i_wen0(i_wen0), .i_addr0(i_addr0),
        .i_data0(i_data0), .i_mask0(i_mask0), .i_busy0(i_busy0),
        .o_busy0(o_busy0), .o_data_valid0(o_data_valid0),
        .i_req1(i_req1), .i_ren1(i_ren1), .i_wen1(i_wen1), .i_addr1(i_addr1),
        .i_data1(i_data1), .i_mask1(i_mask1), .i_busy1(i_busy1),
        .o_busy1(o_busy1), .o_data_valid1(o_data_valid1),
        .o_data(o_data),
        .o_ren(o_ren), .o_wen(o_wen), .o_addr(o_addr), .o_wdata(o_wdata),
        .o_mask(o_mask), .o_dram_busy_in(o_dram_busy_in),
        .i_dram_data(i_dram_data), .i_dram_data_valid(i_dram_data_valid),
        .i_dram_busy(i_dram_busy), .o_err(o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic       p0, p1, b0, b1;
    logic [6:0] exp_ren;
    logic [AW-1:0] exp_addr [7];
    logic [3:0] exp_tag;

    initial begin
        i_rst = 1'b1;
        i_req0 = 1'b0; i_ren0 = 1'b0; i_wen0 = 1'b0; i_busy0 = 1'b0;
        i_req1 = 1'b0; i_ren1 = 1'b0; i_wen1 = 1'b0; i_busy1 = 1'b0;
        i_addr0 = '0; i_addr1 = '0; i_data0 = '0; i_data1 = '0;
        i_mask0 = '0; i_mask1 = '0;
        i_dram_data = '0; i_dram_data_valid = 1'b0; i_dram_busy = 1'b0;
        next_cycle();
        next_cycle();

        // ---- reset behaviour
        i_dram_data_valid = 1'b1; i_req0 = 1'b1;
        #1;
        chk("rst_busy0", o_busy0, 1'b1);
        chk("rst_busy1", o_busy1, 1'b1);
        chk("rst_ren", o_ren, 1'b0);
        chk("rst_wen", o_wen, 1'b0);
        chk("rst_dv0", o_data_valid0, 1'b0);
        chk("rst_dv1", o_data_valid1, 1'b0);
        next_cycle();
        i_dram_data_valid = 1'b0; i_rst = 1'b0;
        #1;
        chk("post_rst_err", o_err, 1'b0);
        chk("post_rst_busy0", o_busy0, 1'b0);
        chk("post_rst_busy1", o_busy1, 1'b1);
        chk("post_rst_dbusy", o_dram_busy_in, 1'b0);

        // ---- same-cycle write from requester 0
        i_wen0 = 1'b1; i_addr0 = 27'h10; i_data0 = 128'hA5; i_mask0 = 16'h00FF;
        #1;
        chk("wr_wen", o_wen, 1'b1);
        chk("wr_addr", o_addr, 27'h10);
        chk("wr_wdata", o_wdata, 128'hA5);
        chk("wr_mask", o_mask, 16'h00FF);
        chk("wr_ren", o_ren, 1'b0);
        chk("wr_busy1", o_busy1, 1'b1);
        next_cycle();

        // ---- two reads from requester 0 (tags 0,0)
        i_wen0 = 1'b0; i_ren0 = 1'b1; i_addr0 = 27'h20;
        #1;
        chk("rd0a_ren", o_ren, 1'b1);
        chk("rd0a_addr", o_addr, 27'h20);
        chk("rd0a_busy1", o_busy1, 1'b1);
        next_cycle();
        i_addr0 = 27'h24;
        #1;
        chk("rd0b_ren", o_ren, 1'b1);
        next_cycle();
        i_ren0 = 1'b0;
        #1;
        chk("head0_dbusy_lo", o_dram_busy_in, 1'b0);
        i_busy0 = 1'b1;
        #1;
        chk("head0_dbusy_hi", o_dram_busy_in, 1'b1);
        i_busy0 = 1'b0;

`ifndef DRAM_ARBITER_RR_EN
        // ---- fixed priority: requester 1 starves while requester 0 requests
        i_req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            chk("starve_busy1", o_busy1, 1'b1);
            chk("starve_busy0", o_busy0, 1'b0);
        end
`endif

        // ---- hand ownership to requester 1
        i_req0 = 1'b0; i_req1 = 1'b1;
        #1;
        chk("hand_busy1_same", o_busy1, 1'b1);
        next_cycle();
        chk("hand_busy1_next", o_busy1, 1'b0);
        chk("hand_busy0_next", o_busy0, 1'b1);

        // ---- one read from requester 1 (FIFO now 0,0,1)
        i_ren1 = 1'b1; i_addr1 = 27'h30;
        #1;
        chk("rd1_ren", o_ren, 1'b1);
        chk("rd1_addr", o_addr, 27'h30);
        next_cycle();
        i_ren1 = 1'b0;

        // ---- returns routed in issue order
        i_dram_data_valid = 1'b1; i_dram_data = 128'h1111;
        #1;
        chk("ret1_dv0", o_data_valid0, 1'b1);
        chk("ret1_dv1", o_data_valid1, 1'b0);
        chk("ret1_data", o_data, 128'h1111);
        next_cycle();
        i_dram_data = 128'h2222;
        #1;
        chk("ret2_dv0", o_data_valid0, 1'b1);
        chk("ret2_dv1", o_data_valid1, 1'b0);
        chk("ret2_data", o_data, 128'h2222);
        next_cycle();
        i_dram_data_valid = 1'b0; i_busy1 = 1'b1; i_busy0 = 1'b0;
        #1;
        chk("head1_busy1_b0lo", o_dram_busy_in, 1'b1);
        i_busy0 = 1'b1;
        #1;
        chk("head1_busy1_b0hi", o_dram_busy_in, 1'b1);
        i_busy1 = 1'b0;
        #1;
        chk("head1_free_b0hi", o_dram_busy_in, 1'b0);
        i_busy0 = 1'b0;
        i_dram_data_valid = 1'b1; i_dram_data = 128'h3333;
        #1;
        chk("ret3_dv1", o_data_valid1, 1'b1);
        chk("ret3_dv0", o_data_valid0, 1'b0);
        chk("ret3_data", o_data, 128'h3333);
        next_cycle();
        i_dram_data_valid = 1'b0; i_busy1 = 1'b1;
        #1;
        chk("empty_dbusy", o_dram_busy_in, 1'b0);
        chk("no_err_yet", o_err, 1'b0);
        i_busy1 = 1'b0;

        // ---- fill the 4-deep tag FIFO from requester 1
        for (int k = 0; k < 4; k++) begin
            i_ren1 = 1'b1; i_addr1 = 27'(64 + k);
            #1;
            chk("fill_ren", o_ren, 1'b1);
            next_cycle();
        end
        i_ren1 = 1'b0;
        #1;
        chk("full_busy0", o_busy0, 1'b1);
        chk("full_busy1", o_busy1, 1'b1);
        i_dram_data_valid = 1'b1; i_dram_data = 128'h4444;
        #1;
        chk("full_pop_dv1", o_data_valid1, 1'b1);
        chk("full_pop_busy1", o_busy1, 1'b1);
        next_cycle();
        i_dram_data_valid = 1'b0;
        #1;
        chk("after_pop_busy1", o_busy1, 1'b0);
        chk("after_pop_busy0", o_busy0, 1'b1);
        i_dram_data_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("drain_dv1", o_data_valid1, 1'b1);
            next_cycle();
        end
        i_dram_data_valid = 1'b0;

        // ---- data with empty FIFO: dropped, sticky error until reset
        i_dram_data_valid = 1'b1; i_dram_data = 128'h5555;
        #1;
        chk("orphan_dv0", o_data_valid0, 1'b0);
        chk("orphan_dv1", o_data_valid1, 1'b0);
        next_cycle();
        i_dram_data_valid = 1'b0;
        #1;
        chk("err_set", o_err, 1'b1);
        next_cycle();
        next_cycle();
        chk("err_sticky", o_err, 1'b1);
        i_req1 = 1'b0; i_req0 = 1'b1; i_rst = 1'b1;
        next_cycle();
        i_rst = 1'b0;
        #1;
        chk("err_cleared", o_err, 1'b0);
        chk("rst_owner0", o_busy0, 1'b0);

        // ---- reset with a read outstanding: late return finds empty FIFO
        i_ren0 = 1'b1; i_addr0 = 27'h50;
        #1;
        chk("mid_ren", o_ren, 1'b1);
        next_cycle();
        i_ren0 = 1'b0; i_rst = 1'b1;
        #1;
        chk("mid_rst_busy0", o_busy0, 1'b1);
        next_cycle();
        i_rst = 1'b0; i_dram_data_valid = 1'b1;
        #1;
        chk("late_dv0", o_data_valid0, 1'b0);
        next_cycle();
        i_dram_data_valid = 1'b0;
        #1;
        chk("late_err", o_err, 1'b1);
        i_rst = 1'b1; i_req0 = 1'b0;
        next_cycle();
        i_rst = 1'b0;

`ifdef DRAM_ARBITER_RR_EN
        // ---- round robin streaming: requesters issue once busy has been low a full cycle
        exp_ren = 7'b1010101;
        exp_addr[0] = 27'h100; exp_addr[2] = 27'h200;
        exp_addr[4] = 27'h100; exp_addr[6] = 27'h200;
        exp_addr[1] = 27'h0;   exp_addr[3] = 27'h0; exp_addr[5] = 27'h0;
        i_addr0 = 27'h100; i_addr1 = 27'h200;
        i_req0 = 1'b1; i_req1 = 1'b1;
        #1;
        p0 = ~o_busy0; p1 = ~o_busy1;
        next_cycle();
        for (int c = 0; c < 7; c++) begin
            b0 = o_busy0; b1 = o_busy1;
            i_ren0 = p0 & ~b0;
            i_ren1 = p1 & ~b1;
            #1;
            chk("rr_ren", o_ren, exp_ren[c]);
            if (exp_ren[c]) chk("rr_addr", o_addr, exp_addr[c]);
            p0 = ~b0; p1 = ~b1;
            next_cycle();
        end
        i_ren0 = 1'b0; i_ren1 = 1'b0; i_req0 = 1'b0; i_req1 = 1'b0;
        exp_tag = 4'b1010;
        i_dram_data_valid = 1'b1;
        for (int r = 0; r < 4; r++) begin
            i_dram_data = 128'(r + 16);
            #1;
            chk("rr_ret_dv1", o_data_valid1, exp_tag[r]);
            chk("rr_ret_dv0", o_data_valid0, ~exp_tag[r]);
            next_cycle();
        end
        i_dram_data_valid = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/dram_arbiter.md
DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 27, DRAM user-interface address width.
REQ-002 Parameter DATA_WIDTH, default 128, data word width.
REQ-003 Parameter MASK_WIDTH, default 16, byte-mask width.
REQ-004 Parameter TAG_DEPTH, default 32, read-tag FIFO depth, power of two, at least 2.
REQ-005 clk  input  1  single clock, the DRAM user-design clock.
REQ-006 i_rst  input  1  synchronous, active-high reset.
REQ-007 i_req0 / i_req1  input  1  requester k has pending work; level signal, independent of o_busyk.
REQ-008 i_ren0 / i_ren1, i_wen0 / i_wen1  input  1  requester k read/write strobe; legal only when o_busyk=0; never both high in one cycle.
REQ-009 i_addr0 / i_addr1  input  ADDR_WIDTH; i_data0 / i_data1  input  DATA_WIDTH; i_mask0 / i_mask1  input  MASK_WIDTH  requester k command fields.
REQ-010 i_busy0 / i_busy1  input  1  requester k cannot accept read data.
REQ-011 o_busy0 / o_busy1  output  1  requester k must not issue a command.
REQ-012 o_data_valid0 / o_data_valid1  output  1  read data on o_data belongs to requester k.
REQ-013 o_data  output  DATA_WIDTH  read data, shared by both requesters.
REQ-014 o_ren, o_wen  output  1; o_addr  output  ADDR_WIDTH; o_wdata  output  DATA_WIDTH; o_mask  output  MASK_WIDTH  command to the DRAM controller.
REQ-015 o_dram_busy_in  output  1  drives the DRAM controller's i_busy.
REQ-016 i_dram_data  input  DATA_WIDTH; i_dram_data_valid  input  1; i_dram_busy  input  1  DRAM controller o_data, o_data_valid and o_busy.
REQ-017 o_err  output  1  sticky error flag.

Function
REQ-018 Register owner (0/1) selects the only requester allowed to issue commands; o_busyk = i_dram_busy | tag_full | (owner != k); it does not depend combinationally on any i_ren/i_wen.
REQ-019 The command path is combinational: o_ren/o_wen/o_addr/o_wdata/o_mask follow the owner's inputs, so a command is accepted on the cycle its strobe is high.
REQ-020 Accepted read: push owner ID into the tag FIFO on the same clock edge; accepted write: no tag.
REQ-021 On i_dram_data_valid with FIFO non-empty: o_data_validk = 1 for the head ID k, o_data = i_dram_data, pop the FIFO on the same edge.
REQ-022 o_dram_busy_in = i_busy of the head requester when FIFO non-empty, else 0.
REQ-023 Push and pop in the same cycle leave the count unchanged; tag_full = (count == TAG_DEPTH); read and write pointers wrap modulo TAG_DEPTH.
REQ-024 i_dram_data_valid with FIFO empty: data dropped, both o_data_validk stay 0, o_err set until reset.
REQ-025 Owner update, RR mode: if the other port's i_req is high and the owner either accepted a command this cycle or has i_req low, owner flips on the next edge; otherwise it holds.
REQ-026 Owner update, fixed mode: owner becomes 0 when i_req0 = 1; it becomes 1 when i_req0 = 0 and i_req1 = 1; otherwise it holds.
REQ-027 A handover costs exactly one idle command cycle; read data ordering per requester is strict issue order.

Reset
REQ-028 On i_rst, the following take effect on the next edge: owner = 0, FIFO empty (both pointers 0, count 0), o_err = 0.
REQ-029 During reset, o_busy0 = o_busy1 = 1, o_ren = o_wen = 0, and o_data_valid0 = o_data_valid1 = 0.
REQ-030 DRAM responses arriving after a mid-operation reset find an empty FIFO and are handled per REQ-024.

Configuration
REQ-031 Macro DRAM_ARBITER_RR_EN defined: owner follows the round-robin rule of REQ-025.
REQ-032 Macro DRAM_ARBITER_RR_EN undefined: owner follows the fixed-priority rule of REQ-026, requester 0 highest; requester 1 can starve.

Verification
REQ-033 Reset, then i_req0 = 1 and i_wen0 = 1 with addr 0x10 -> o_wen = 1 and o_addr = 0x10 in the same cycle; o_busy1 = 1 throughout.
REQ-034 RR build, both requesters stream reads -> accepts alternate in the pattern 0, gap, 1, gap, 0; returned data is routed to the issuing port in order.
REQ-035 TAG_DEPTH = 4, four reads accepted with no returns -> o_busy0 = o_busy1 = 1; one i_dram_data_valid -> busy of the owner deasserts on the next cycle.
REQ-036 Head tag = 1 and i_busy1 = 1 -> o_dram_busy_in = 1; i_busy0 toggling does not affect o_dram_busy_in.
REQ-037 Assert i_dram_data_valid with FIFO empty -> no o_data_validk pulse and o_err = 1 until i_rst.
REQ-038 Fixed build, i_req0 and i_req1 both held high -> requester 1 is never granted; after i_req0 drops, owner = 1 on the next edge.
